config_spi_bridge: RTL and testbench

Serial host-side front end for the `config_reg` register file. It receives 24-bit SPI mode-0 frames from an external controller, oversampled in the `clk` domain. On write frames it issues single-cycle register writes on `write`/`address`/`data_in`. On read frames it drives `address`, captures `data_out` and shifts the value back on `miso`. The block sits directly upstream of `config_reg` and is the only master of its write port.

---
 rtl/config_pkg.sv | 46 ++++
 rtl/sync_edge_detect.sv | 45 ++++
 rtl/config_spi_bridge.sv | 237 +++++++++++++++++++++++
 tb/tb_config_spi_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : config_pkg
// Purpose  : Shared definitions for the config_reg SPI bridge: register map,
//            serial frame geometry and bridge state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package config_pkg;

    // Register map of config_reg; the encoding is the 3-bit frame address.
    typedef enum logic [2:0] {
        adc0_reg       = 3'd0,
        adc1_reg       = 3'd1,
        adc2_reg       = 3'd2,
        adc3_reg       = 3'd3,
        analog_test    = 3'd4,
        digital_test   = 3'd5,
        amp_gain       = 3'd6,
        digital_config = 3'd7
    } register;

    // Frame geometry: rw | addr[2:0] | reserved[3:0] | data[15:0], MSB first.
    localparam int FRAME_BITS = 24;
    localparam int HDR_BITS   = 8;
    localparam int RSVD_MSB   = 19;
    localparam int RSVD_LSB   = 16;

    // Reserved field position relative to the 8-bit header.
    localparam int HDR_RSVD_MSB = RSVD_MSB - (FRAME_BITS - HDR_BITS);
    localparam int HDR_RSVD_LSB = RSVD_LSB - (FRAME_BITS - HDR_BITS);

    // Width of the per-frame rising-edge counter.
    localparam int CNT_W = $clog2(FRAME_BITS);

    // Bridge state machine encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        FETCH  = 3'd2,
        DATA   = 3'd3,
        COMMIT = 3'd4,
        DRAIN  = 3'd5
    } state_e;

endpackage : config_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Multi-flop synchronizer for an asynchronous level, with
//            single-cycle rise/fall pulses derived from the synchronized value.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the raw input into the synchronizer chain and remember the last output.
    always_comb begin
        sync_d = (sync_q << 1) | SYNC_STAGES'(d);
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise =  q & ~prev_q;
    assign fall = ~q &  prev_q;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/config_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : config_spi_bridge
// Purpose  : SPI mode-0 slave, oversampled in the clk domain, that turns
//            24-bit frames into register writes/reads on config_reg.
// Revision : 1.0 - initial release
// ============================================================================
module config_spi_bridge
    import config_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              frame_err
);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sclk),
        .q     (sclk_lvl_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // cs_n resets to 0 so that a frame already in flight when reset releases
    // never shows up as a falling edge; only a fresh cs_n fall starts a frame.
    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cs_n),
        .q     (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_s;

    // Plain level synchronizer for the data input.
    always_comb begin
        mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
    end

    // Data-input synchronizer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [HDR_BITS-2:0] hdr_q, hdr_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic                rw_q, rw_d;
    logic                fetch_ph_q, fetch_ph_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;
    logic                miso_q, miso_d;
    logic                frame_err_q, frame_err_d;

    // Header and data word as they look including the bit arriving this cycle.
    logic [HDR_BITS-1:0] hdr_full;
    logic [DATA_W-1:0]   sr_shift_in;

    assign hdr_full    = {hdr_q, mosi_s};
    assign sr_shift_in = {sr_q[DATA_W-2:0], mosi_s};

    // Next-state, shift-register and output-register logic.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        hdr_d       = hdr_q;
        sr_d        = sr_q;
        rw_d        = rw_q;
        fetch_ph_d  = fetch_ph_q;
        address_d   = address_q;
        data_in_d   = data_in_q;
        miso_d      = miso_q;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = HEADER;
                    bit_cnt_d = '0;
                    hdr_d     = '0;
                end
            end

            HEADER: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    hdr_d     = hdr_full[HDR_BITS-2:0];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(HDR_BITS - 1)) begin
                        if (hdr_full[HDR_RSVD_MSB:HDR_RSVD_LSB] != '0) begin
                            frame_err_d = 1'b1;
                            state_d     = DRAIN;
                        end else begin
                            rw_d       = hdr_full[HDR_BITS-1];
                            address_d  = hdr_full[HDR_BITS-2 -: ADDR_W];
                            fetch_ph_d = 1'b0;
                            state_d    = hdr_full[HDR_BITS-1] ? DATA : FETCH;
                        end
                    end
                end
            end

            // Cycle 1 presents the address; cycle 2 captures the read data.
            FETCH: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                    state_d     = IDLE;
                end else if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    sr_d    = data_out;
                    state_d = DATA;
                end
            end

            DATA: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (rw_q) begin
                        sr_d = sr_shift_in;
                    end
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        if (rw_q) begin
                            data_in_d = sr_shift_in;
                            state_d   = COMMIT;
                        end else begin
                            state_d   = DRAIN;
                        end
                    end
                end else if (sclk_fall && !rw_q) begin
                    miso_d = sr_q[DATA_W-1];
                    sr_d   = {sr_q[DATA_W-2:0], 1'b0};
                end
            end

            COMMIT: begin
                state_d = DRAIN;
            end

            // Last read bit stays on miso until the controller deselects.
            DRAIN: begin
                if (cs_s) begin
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            hdr_q       <= '0;
            sr_q        <= '0;
            rw_q        <= 1'b0;
            fetch_ph_q  <= 1'b0;
            address_q   <= '0;
            data_in_q   <= '0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            hdr_q       <= hdr_d;
            sr_q        <= sr_d;
            rw_q        <= rw_d;
            fetch_ph_q  <= fetch_ph_d;
            address_q   <= address_d;
            data_in_q   <= data_in_d;
            miso_q      <= miso_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign write     = (state_q == COMMIT);
    assign address   = address_q;
    assign data_in   = data_in_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;

endmodule : config_spi_bridge
`default_nettype wire

// File: tb/tb_config_spi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_config_spi_bridge
// Purpose  : Self-checking bench for config_spi_bridge with a config_reg
//            stand-in and an expected-result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_spi_bridge;
    import config_pkg::*;

    localparam int ADDR_W      = 3;
    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int CLK_P       = 10;
    localparam int HALF_SCLK   = 8 * CLK_P;
    localparam int MIN_GAP     = SYNC_STAGES + 2;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              sclk  = 1'b0;
    logic              cs_n  = 1'b1;
    logic              mosi  = 1'b0;
    logic              miso;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              frame_err;

    always #(CLK_P/2) clk = ~clk;

    config_spi_bridge #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .write     (write),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // config_reg power-on contents.
    function automatic logic [15:0] reg_default(input int idx);
        case (idx)
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'h1234;
            3:       return 16'h00FF;
            4:       return 16'hABCD;
            5:       return 16'h0F0F;
            6:       return 16'h8000;
            default: return 16'h0001;
        endcase
    endfunction

    // config_reg stand-in: written only by the DUT, read combinationally.
    logic [15:0] cfg_model [8];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) cfg_model[i] <= reg_default(i);
        end else if (write) begin
            cfg_model[address] <= data_in;
        end
    end
    assign data_out = cfg_model[address];

    // Bench-side view of what config_reg should hold, updated from stimulus.
    logic [15:0] shadow [8];

    logic [18:0] exp_wr_q [$];
    logic [15:0] exp_rd_q [$];
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_wr   = 0;
    int n_ferr = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-strobe and error-pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && write) begin
            logic [18:0] exp_wr;
            n_wr++;
            check_value("wr_expected", 32'(exp_wr_q.size() > 0), 32'd1);
            if (exp_wr_q.size() > 0) begin
                exp_wr = exp_wr_q.pop_front();
                check_value("wr_address", 32'(address), 32'(exp_wr[18:16]));
                check_value("wr_data", 32'(data_in), 32'(exp_wr[15:0]));
            end
        end
        if (reset && frame_err) n_ferr++;
    end

    task automatic reset_shadow();
        for (int i = 0; i < 8; i++) shadow[i] = reg_default(i);
    endtask

    task automatic check_reset_outputs();
        check_value("rst_miso", 32'(miso), 32'd0);
        check_value("rst_write", 32'(write), 32'd0);
        check_value("rst_address", 32'(address), 32'd0);
        check_value("rst_data_in", 32'(data_in), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_frame_err", 32'(frame_err), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #(3*CLK_P);
        check_reset_outputs();
        reset_shadow();
        #(2*CLK_P);
        reset = 1'b1;
        #(10*CLK_P);
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        #(HALF_SCLK);
    endtask

    task automatic cs_end(input int gap_clks);
        #(HALF_SCLK);
        cs_n = 1'b1;
        mosi = 1'b0;
        #(gap_clks*CLK_P);
    endtask

    // Mode-0 controller: drive mosi while sclk low, sample miso at rising sclk.
    task automatic spi_shift(input logic [23:0] frame, input int nbits, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[23-i];
            #(HALF_SCLK);
            rx   = {rx[14:0], miso};
            sclk = 1'b1;
            #(HALF_SCLK);
            sclk = 1'b0;
        end
    endtask

    task automatic write_frame(input logic [2:0] a, input logic [15:0] d, input int gap);
        logic [15:0] rx;
        exp_wr_q.push_back({a, d});
        shadow[a] = d;
        cs_start();
        spi_shift({1'b1, a, 4'b0000, d}, 24, rx);
        cs_end(gap);
    endtask

    task automatic read_frame(input logic [2:0] a, input string tag, input int gap);
        logic [15:0] rx;
        logic [15:0] exp_rd;
        exp_rd_q.push_back(shadow[a]);
        cs_start();
        spi_shift({1'b0, a, 4'b0000, 16'h0000}, 24, rx);
        cs_end(gap);
        exp_rd = exp_rd_q.pop_front();
        check_value(tag, 32'(rx), 32'(exp_rd));
    endtask

    initial begin
        #(1000000);
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int          wr0;
        int          fe0;
        logic [15:0] rx;

        // Reset values.
        do_reset();

        // Single write to amp_gain.
        wr0 = n_wr; fe0 = n_ferr;
        write_frame(amp_gain, 16'hABCD, 10);
        check_value("wr1_count", 32'(n_wr - wr0), 32'd1);
        check_value("wr1_ferr", 32'(n_ferr - fe0), 32'd0);
        check_value("wr1_busy_after", 32'(busy), 32'd0);
        check_value("hold_address", 32'(address), 32'd6);
        check_value("hold_data_in", 32'(data_in), 32'hABCD);

        // Reads of power-on contents after a fresh reset.
        do_reset();
        fe0 = n_ferr;
        read_frame(analog_test, "rd_analog_test", 10);
        read_frame(adc0_reg, "rd_adc0_reg", 10);
        check_value("rd_ferr", 32'(n_ferr - fe0), 32'd0);
        check_value("rd_miso_idle", 32'(miso), 32'd0);

        // Write aborted by cs_n high after 12 bits.
        wr0 = n_wr; fe0 = n_ferr;
        cs_start();
        spi_shift({1'b1, 3'd2, 4'b0000, 16'h1111}, 12, rx);
        check_value("abort_busy_mid", 32'(busy), 32'd1);
        cs_end(10);
        check_value("abort_wr_count", 32'(n_wr - wr0), 32'd0);
        check_value("abort_ferr", 32'(n_ferr - fe0), 32'd1);
        check_value("abort_busy_after", 32'(busy), 32'd0);

        // Non-zero reserved field.
        wr0 = n_wr; fe0 = n_ferr;
        cs_start();
        spi_shift({1'b1, 3'd2, 4'b0101, 16'h1234}, 24, rx);
        check_value("rsvd_busy_drain", 32'(busy), 32'd1);
        cs_end(10);
        check_value("rsvd_wr_count", 32'(n_wr - wr0), 32'd0);
        check_value("rsvd_ferr", 32'(n_ferr - fe0), 32'd1);
        check_value("rsvd_busy_after", 32'(busy), 32'd0);

        // Reset asserted at bit 18 of a write frame.
        wr0 = n_wr; fe0 = n_ferr;
        write_frame(digital_test, 16'h1357, 10);
        cs_start();
        spi_shift({1'b1, 3'd3, 4'b0000, 16'h2468}, 18, rx);
        reset = 1'b0;
        #(3*CLK_P);
        check_reset_outputs();
        reset_shadow();
        #(2*CLK_P);
        reset = 1'b1;
        #(HALF_SCLK);
        cs_n = 1'b1;
        mosi = 1'b0;
        #(10*CLK_P);
        write_frame(adc3_reg, 16'h2468, 10);
        check_value("rstmid_wr_count", 32'(n_wr - wr0), 32'd2);
        check_value("rstmid_ferr", 32'(n_ferr - fe0), 32'd0);
        read_frame(adc3_reg, "rstmid_rd_adc3", 10);
        read_frame(digital_test, "rstmid_rd_digital_test", 10);

        // Back-to-back writes at minimum cs_n gap, then read-back.
        wr0 = n_wr;
        write_frame(adc1_reg, 16'h0001, MIN_GAP);
        write_frame(adc2_reg, 16'hFFFF, MIN_GAP);
        write_frame(adc3_reg, 16'h5EAB, MIN_GAP);
        check_value("b2b_wr_count", 32'(n_wr - wr0), 32'd3);
        read_frame(adc1_reg, "b2b_rd_adc1", MIN_GAP);
        read_frame(adc2_reg, "b2b_rd_adc2", MIN_GAP);
        read_frame(adc3_reg, "b2b_rd_adc3", 10);

        check_value("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check_value("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_config_spi_bridge
`default_nettype wire
